// File: rtl/seg7_pkg.sv
// seg7_pkg: shared digit width, digit limit and active-high segment patterns {g,f,e,d,c,b,a}
package seg7_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
endpackage

// File: rtl/seconds_digit_counter_if.sv
// seconds_digit_counter_if: control inputs and display/strobe outputs of the seconds digit counter
interface seconds_digit_counter_if;
  logic run;
  logic clear;
  logic dir;
  logic tick;
  logic carry;
  logic [seg7_pkg::DIGIT_W-1:0] digit;
  logic [6:0] segments;
  logic dp;
  modport master (output run, clear, dir, input tick, carry, digit, segments, dp);
  modport slave (input run, clear, dir, output tick, carry, digit, segments, dp);
endinterface

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational BCD digit to active-high 7-segment pattern; out-of-range digits blank
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [6:0]         segments_o
);
  always_comb begin
    segments_o = SEG_BLANK;
    case (digit_i)
      4'd0: segments_o = SEG_0;
      4'd1: segments_o = SEG_1;
      4'd2: segments_o = SEG_2;
      4'd3: segments_o = SEG_3;
      4'd4: segments_o = SEG_4;
      4'd5: segments_o = SEG_5;
      4'd6: segments_o = SEG_6;
      4'd7: segments_o = SEG_7;
      4'd8: segments_o = SEG_8;
      4'd9: segments_o = SEG_9;
      default: segments_o = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seconds_digit_counter.sv
// seconds_digit_counter: divides clk into a 1 Hz tick and counts it as an up/down BCD digit
module seconds_digit_counter
  import seg7_pkg::*;
#(
  parameter int DIV = 10_000_000
) (
  input logic clk,
  input logic reset,
  seconds_digit_counter_if.slave bus
);
  localparam int CNT_W = $clog2(DIV);
  logic [CNT_W-1:0]   pre_q, pre_d;
  logic [DIGIT_W-1:0] digit_q, digit_d, nxt;
  logic               tick_q, tick_d, carry_q, carry_d, wrap, digit_wrap;
  // Out-of-range digits are unreachable; they recover to 0 on the next tick.
  always_comb begin
    wrap       = bus.run && (pre_q == CNT_W'(DIV - 1));
    digit_wrap = bus.dir ? (digit_q == '0) : (digit_q == MAX_DIGIT);
    nxt        = bus.dir ? ((digit_q == '0) ? MAX_DIGIT : (digit_q <= MAX_DIGIT) ? digit_q - 1'b1 : '0)
                         : ((digit_q < MAX_DIGIT) ? digit_q + 1'b1 : '0);
    pre_d      = bus.run ? (wrap ? '0 : pre_q + 1'b1) : pre_q;
    digit_d    = wrap ? nxt : digit_q;
    tick_d     = wrap;
    carry_d    = wrap && digit_wrap;
  end
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      pre_q   <= '0;
      digit_q <= '0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      digit_q <= digit_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
    end
  end
  assign bus.tick  = tick_q;
  assign bus.carry = carry_q;
  assign bus.digit = digit_q;
  assign bus.dp    = pre_q < CNT_W'(DIV / 2);
  seg7_decoder u_dec (
    .digit_i    (digit_q),
    .segments_o (bus.segments)
  );
endmodule

// File: tb/tb_seconds_digit_counter.sv
// tb_seconds_digit_counter: directed checks of prescaler, up/down digit, strobes, dp and clear with DIV = 4
module tb_seconds_digit_counter;
  logic clk = 1'b0;
  logic reset;
  int n = 0;
  int fails = 0;
  logic [6:0] segt [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  seconds_digit_counter_if bus ();
  seconds_digit_counter #(.DIV(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [13:0] obs();
    return {bus.tick, bus.carry, bus.digit, bus.segments, bus.dp};
  endfunction

  function automatic logic [13:0] ex(logic t, logic c, logic [3:0] d, logic p);
    return {t, c, d, segt[d], p};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.run = 1'b1; bus.clear = 1'b0; bus.dir = 1'b0;
    step(); step();
    n++; if (obs() !== ex(0, 0, 0, 1)) begin fails++; $display("FAIL reset_state: got %h want %h", obs(), ex(0, 0, 0, 1)); end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n++; if (bus.tick !== 1'b0) begin fails++; $display("FAIL reset_no_early_tick c=%0d: got %b want 0", c, bus.tick); end
    end
    step();
    n++; if (obs() !== ex(1, 0, 1, 1)) begin fails++; $display("FAIL reset_first_tick: got %h want %h", obs(), ex(1, 0, 1, 1)); end
  endtask

  task automatic test_up_wrap();
    for (int k = 2; k <= 10; k++) begin
      for (int c = 0; c < 3; c++) begin
        step();
        n++; if ({bus.tick, bus.carry} !== 2'b00) begin fails++; $display("FAIL up_gap k=%0d: got %b want 00", k, {bus.tick, bus.carry}); end
      end
      step();
      n++; if (obs() !== ex(1, k == 10, 4'(k % 10), 1)) begin fails++; $display("FAIL up_tick k=%0d: got %h want %h", k, obs(), ex(1, k == 10, 4'(k % 10), 1)); end
    end
    step();
    n++; if (obs() !== ex(0, 0, 0, 1)) begin fails++; $display("FAIL up_carry_one_cycle: got %h want %h", obs(), ex(0, 0, 0, 1)); end
  endtask

  task automatic test_down_wrap();
    bus.dir = 1'b1;
    step();
    n++; if (obs() !== ex(0, 0, 0, 0)) begin fails++; $display("FAIL down_pre2: got %h want %h", obs(), ex(0, 0, 0, 0)); end
    step();
    n++; if (obs() !== ex(0, 0, 0, 0)) begin fails++; $display("FAIL down_pre3: got %h want %h", obs(), ex(0, 0, 0, 0)); end
    step();
    n++; if (obs() !== ex(1, 1, 9, 1)) begin fails++; $display("FAIL down_wrap: got %h want %h", obs(), ex(1, 1, 9, 1)); end
    step(); step(); step(); step();
    n++; if (obs() !== ex(1, 0, 8, 1)) begin fails++; $display("FAIL down_next: got %h want %h", obs(), ex(1, 0, 8, 1)); end
  endtask

  task automatic test_pause();
    step(); step();
    n++; if (obs() !== ex(0, 0, 8, 0)) begin fails++; $display("FAIL pause_pre2: got %h want %h", obs(), ex(0, 0, 8, 0)); end
    bus.run = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      n++; if (obs() !== ex(0, 0, 8, 0)) begin fails++; $display("FAIL pause_hold c=%0d: got %h want %h", c, obs(), ex(0, 0, 8, 0)); end
    end
    bus.run = 1'b1;
    step();
    n++; if (obs() !== ex(0, 0, 8, 0)) begin fails++; $display("FAIL pause_resume1: got %h want %h", obs(), ex(0, 0, 8, 0)); end
    step();
    n++; if (obs() !== ex(1, 0, 7, 1)) begin fails++; $display("FAIL pause_resume_tick: got %h want %h", obs(), ex(1, 0, 7, 1)); end
  endtask

  task automatic test_clear_collision();
    step(); step(); step(); step();
    n++; if (obs() !== ex(1, 0, 6, 1)) begin fails++; $display("FAIL clr_setup6: got %h want %h", obs(), ex(1, 0, 6, 1)); end
    step(); step(); step(); step();
    n++; if (obs() !== ex(1, 0, 5, 1)) begin fails++; $display("FAIL clr_setup5: got %h want %h", obs(), ex(1, 0, 5, 1)); end
    step(); step(); step();
    n++; if (obs() !== ex(0, 0, 5, 0)) begin fails++; $display("FAIL clr_pre3: got %h want %h", obs(), ex(0, 0, 5, 0)); end
    bus.clear = 1'b1;
    step();
    n++; if (obs() !== ex(0, 0, 0, 1)) begin fails++; $display("FAIL clr_wins: got %h want %h", obs(), ex(0, 0, 0, 1)); end
    bus.clear = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n++; if (obs() !== ex(0, 0, 0, c == 0)) begin fails++; $display("FAIL clr_gap c=%0d: got %h want %h", c, obs(), ex(0, 0, 0, c == 0)); end
    end
    step();
    n++; if (obs() !== ex(1, 1, 9, 1)) begin fails++; $display("FAIL clr_next_tick: got %h want %h", obs(), ex(1, 1, 9, 1)); end
  endtask

  task automatic test_dir_timing();
    step();
    n++; if (obs() !== ex(0, 0, 9, 1)) begin fails++; $display("FAIL dir_dp1: got %h want %h", obs(), ex(0, 0, 9, 1)); end
    bus.dir = 1'b0;
    step();
    n++; if (obs() !== ex(0, 0, 9, 0)) begin fails++; $display("FAIL dir_dp2: got %h want %h", obs(), ex(0, 0, 9, 0)); end
    bus.dir = 1'b1;
    step();
    n++; if (obs() !== ex(0, 0, 9, 0)) begin fails++; $display("FAIL dir_dp3: got %h want %h", obs(), ex(0, 0, 9, 0)); end
    bus.dir = 1'b0;
    step();
    n++; if (obs() !== ex(1, 1, 0, 1)) begin fails++; $display("FAIL dir_on_tick_cycle: got %h want %h", obs(), ex(1, 1, 0, 1)); end
    bus.dir = 1'b1;
    step();
    n++; if (obs() !== ex(0, 0, 0, 1)) begin fails++; $display("FAIL dir_mid1: got %h want %h", obs(), ex(0, 0, 0, 1)); end
    bus.dir = 1'b0;
    step(); step();
    n++; if (obs() !== ex(0, 0, 0, 0)) begin fails++; $display("FAIL dir_mid3: got %h want %h", obs(), ex(0, 0, 0, 0)); end
    step();
    n++; if (obs() !== ex(1, 0, 1, 1)) begin fails++; $display("FAIL dir_mid_ignored: got %h want %h", obs(), ex(1, 0, 1, 1)); end
  endtask

  task automatic test_reset_mid_second();
    step(); step();
    n++; if (obs() !== ex(0, 0, 1, 0)) begin fails++; $display("FAIL rstmid_pre2: got %h want %h", obs(), ex(0, 0, 1, 0)); end
    reset = 1'b1;
    step();
    n++; if (obs() !== ex(0, 0, 0, 1)) begin fails++; $display("FAIL rstmid_reset: got %h want %h", obs(), ex(0, 0, 0, 1)); end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n++; if (bus.tick !== 1'b0) begin fails++; $display("FAIL rstmid_gap c=%0d: got %b want 0", c, bus.tick); end
    end
    step();
    n++; if (obs() !== ex(1, 0, 1, 1)) begin fails++; $display("FAIL rstmid_tick: got %h want %h", obs(), ex(1, 0, 1, 1)); end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_pause();
    test_clear_collision();
    test_dir_timing();
    test_reset_mid_second();
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule

// File: doc/seconds_digit_counter.md
Name: seconds_digit_counter

Overview:
- Upstream timing and count stage for the 7-segment top level.
- Divides the 10 MHz board clock into a 1 Hz tick and counts that tick as a single BCD digit 0..9, up or down.
- Presents the digit in binary and as active-high segment patterns, plus a half-second blink on the decimal point.
- The top level wires `segments`/`dp` to uo_out and `digit`/`carry` to uio_out.

Parameters:
- DIV, 10_000_000, clock cycles per tick; must be >= 2. Simulation uses 4.
- CNT_W, $clog2(DIV), prescaler width (localparam, not overridable; 24 at default).

Ports:
- clk  input  1  system clock, 10 MHz.
- reset  input  1  synchronous, active-high; top level drives it as !rst_n.
- run  input  1  1 = prescaler advances; 0 = prescaler and digit hold.
- clear  input  1  synchronous clear of prescaler and digit, independent of run.
- dir  input  1  0 = count up, 1 = count down; sampled only on the tick cycle.
- tick  output  1  one-cycle pulse on the cycle the prescaler wraps.
- carry  output  1  one-cycle pulse coincident with tick when the digit wraps (9->0 up, 0->9 down).
- digit  output  4  current digit, binary 0..9.
- segments  output  7  {g,f,e,d,c,b,a}, active-high, decoded from digit.
- dp  output  1  decimal point, high during the first half of each second.

Behaviour:
- All state updates on posedge clk. Priority: reset > clear > run.
- Reset and clear produce identical results:
  - prescaler = 0, digit = 0, tick = 0, carry = 0
  - segments = 7'h3F, dp = 1
- Reset or clear mid-second discards the partial count; the next tick comes DIV run-cycles later.
- Prescaler `pre` (CNT_W bits):
  - With run = 1: if pre == DIV-1 then pre <= 0 and tick is asserted for that one cycle, else pre <= pre+1.
  - With run = 0: pre holds and tick stays 0.
- tick and carry are registered. They assert on the clock edge where pre wraps and deassert on the next edge.
- Digit, on the tick edge:
  - Up (dir = 0): 0..8 -> +1; 9 -> 0 with carry = 1.
  - Down (dir = 1): 1..9 -> -1; 0 -> 9 with carry = 1.
  - Digit updates on the same edge tick asserts (0 extra latency). On all non-tick cycles digit holds.
- A dir change between ticks has no effect until the next tick. dir on the tick cycle itself takes effect immediately.
- run deasserted for any number of cycles: no drift; the remaining count resumes exactly where it stopped.
- clear and a tick condition in the same cycle: clear wins, digit = 0, no tick, no carry.
- digit never leaves 0..9. Illegal values (unreachable) decode to segments = 7'h00 and next-digit = 0 (defensive).
- Decoder is combinational from the registered digit, so segments change on the same edge as digit:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66
  - 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F
- dp = (pre < DIV/2), combinational from the registered prescaler. With DIV = 4, dp is high for pre = 0,1.
- No handshake. Downstream consumers sample tick/carry as single-cycle strobes in the clk domain.

Decomposition:
- Shared package `seg7_pkg`:
  - segment pattern constants SEG_0..SEG_9 and SEG_BLANK
  - digit width localparam DIGIT_W = 4
  - MAX_DIGIT = 9
- Sub-module `seg7_decoder`: purely combinational, input digit[3:0], output segments[6:0]. It is reused later by the top level for other display sources.
- Prescaler, digit counter and strobe registers live in `seconds_digit_counter` itself.

Test Plan (DIV = 4):
- Reset: hold reset 2 cycles with run = 1 -> digit = 0, segments = 3F, dp = 1, tick = carry = 0. First tick 4 cycles after reset release, digit becomes 1, segments = 06.
- Up wrap: run = 1, dir = 0 for 40 cycles -> ticks every 4 cycles; digit goes 1..9, then 0 on the 10th tick with carry = 1 for exactly that cycle only.
- Down wrap: from digit = 0, dir = 1 -> next tick gives digit = 9, carry = 1, segments = 6F. Following tick gives 8, carry = 0.
- Pause: drop run at pre = 2 for 10 cycles -> digit and dp frozen, no tick. On run = 1, tick occurs 2 cycles later.
- Clear collision: assert clear exactly on the cycle pre = 3 with digit = 5 -> digit = 0, tick = 0, carry = 0, pre = 0. Next tick 4 cycles later.
- dp and dir timing: toggle dir mid-second -> digit direction changes only at the next tick. dp reads 1,1,0,0 repeating each second.
